// File: rtl/wildcard_match_table.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wildcard_match_table
//
// Programmable, pipelined wildcard pattern matcher: a runtime-reconfigurable
// form of casex-style decoding. The table holds ENTRIES patterns of WIDTH
// bits. Every pattern has a per-bit care mask, and a care bit of 0 makes that
// bit a don't-care. Each lookup word is compared against all enabled entries.
// The result appears two cycles later as a hit flag, the lowest matching
// index, and the full hit map.
//
// Parameters:
//   WIDTH    bits per data word / pattern
//   ENTRIES  number of table entries (2..16)
//   IDX_W    index width, 2**IDX_W >= ENTRIES
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (clears table and pipeline)
//   cfg_we       table write strobe for entry cfg_idx (ignored if >= ENTRIES)
//   cfg_idx      entry index to write
//   cfg_pattern  pattern value
//   cfg_care     care mask, 1 = bit must match
//   cfg_en       entry enable, written with the entry
//   in_valid     lookup request valid
//   in_data      lookup word
//   out_valid    result valid (2 cycles after in_valid)
//   out_hit      at least one entry matched
//   out_idx      lowest matching index, 0 on miss
//   out_hitmap   per-entry match vector
//
// Optional build macro WILDCARD_MATCH_STATS_EN adds:
//   stat_sel     entry whose hit counter is shown on stat_hits
//   stat_hits    16-bit saturating hit count of entry stat_sel (0 if out of range)
//   stat_miss    16-bit saturating count of valid lookups with no hit
// -----------------------------------------------------------------------------
module wildcard_match_table #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [WIDTH-1:0]   cfg_pattern,
    input  logic [WIDTH-1:0]   cfg_care,
    input  logic               cfg_en,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
`ifdef WILDCARD_MATCH_STATS_EN
    input  logic [IDX_W-1:0]   stat_sel,
    output logic [15:0]        stat_hits,
    output logic [15:0]        stat_miss,
`endif
    output logic               out_valid,
    output logic               out_hit,
    output logic [IDX_W-1:0]   out_idx,
    output logic [ENTRIES-1:0] out_hitmap
);

    // -------------------------------------------------------------------------
    // Pattern table
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]   pattern_q [ENTRIES];
    logic [WIDTH-1:0]   care_q    [ENTRIES];
    logic [ENTRIES-1:0] en_q;

    // One-hot write decode. An out-of-range cfg_idx selects no entry, so such
    // a write leaves the table untouched.
    logic [ENTRIES-1:0] wr_sel;

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            wr_sel[i] = cfg_we && (32'(cfg_idx) == i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                pattern_q[i] <= '0;
                care_q[i]    <= '0;
            end
            en_q <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (wr_sel[i]) begin
                    pattern_q[i] <= cfg_pattern;
                    care_q[i]    <= cfg_care;
                    en_q[i]      <= cfg_en;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Match compare against the table contents as they are before the edge,
    // so a write and a lookup in the same cycle see the old entry.
    // -------------------------------------------------------------------------
    logic [ENTRIES-1:0] hitmap_d;

    always_comb begin
        hitmap_d = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            hitmap_d[i] = en_q[i] && (((in_data ^ pattern_q[i]) & care_q[i]) == '0);
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: valid flag and hit map. The hit map is zeroed for idle cycles
    // so stage 2 only has to copy it through.
    // -------------------------------------------------------------------------
    logic               s1_valid_q;
    logic [ENTRIES-1:0] s1_hitmap_q;
    logic [ENTRIES-1:0] s1_hitmap_d;

    assign s1_hitmap_d = in_valid ? hitmap_d : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_hitmap_q <= '0;
        end else begin
            s1_valid_q  <= in_valid;
            s1_hitmap_q <= s1_hitmap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: priority encode (lowest index wins) and output registers.
    // -------------------------------------------------------------------------
    logic               s1_any;
    logic [IDX_W-1:0]   win_idx_d;
    logic               win_found;

    assign s1_any = |s1_hitmap_q;

    always_comb begin
        win_idx_d = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!win_found && s1_hitmap_q[i]) begin
                win_idx_d = IDX_W'(i);
                win_found = 1'b1;
            end
        end
    end

    logic               out_valid_q;
    logic               out_hit_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [ENTRIES-1:0] out_hitmap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_hit_q    <= 1'b0;
            out_idx_q    <= '0;
            out_hitmap_q <= '0;
        end else begin
            out_valid_q  <= s1_valid_q;
            // s1_hitmap_q is already zero on idle cycles, so hit/idx/map are
            // naturally 0 whenever out_valid is 0.
            out_hit_q    <= s1_any;
            out_idx_q    <= win_idx_d;
            out_hitmap_q <= s1_hitmap_q;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_hit    = out_hit_q;
    assign out_idx    = out_idx_q;
    assign out_hitmap = out_hitmap_q;

`ifdef WILDCARD_MATCH_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: counters advance on the same edge that registers the result.
    // A table write to an entry takes priority over a coincident increment.
    // -------------------------------------------------------------------------
    logic [15:0] hit_cnt_q [ENTRIES];
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                hit_cnt_q[i] <= '0;
            end
            miss_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (wr_sel[i]) begin
                    hit_cnt_q[i] <= '0;
                end else if (s1_valid_q && s1_any && (win_idx_d == IDX_W'(i))
                             && (hit_cnt_q[i] != '1)) begin
                    hit_cnt_q[i] <= hit_cnt_q[i] + 16'd1;
                end
            end
            if (s1_valid_q && !s1_any && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        stat_hits = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (32'(stat_sel) == i) begin
                stat_hits = hit_cnt_q[i];
            end
        end
    end

    assign stat_miss = miss_cnt_q;
`endif

endmodule

// File: tb/tb_wildcard_match_table.sv
`timescale 1ns/1ps
module tb_wildcard_match_table;

    localparam int WIDTH   = 8;
    localparam int ENTRIES = 4;
    localparam int IDX_W   = 2;
    // Result word: {valid, hit, idx, hitmap}
    localparam int RW      = 2 + IDX_W + ENTRIES;

    logic               clk;
    logic               rst;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [WIDTH-1:0]   cfg_pattern;
    logic [WIDTH-1:0]   cfg_care;
    logic               cfg_en;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_hit;
    logic [IDX_W-1:0]   out_idx;
    logic [ENTRIES-1:0] out_hitmap;
`ifdef WILDCARD_MATCH_STATS_EN
    logic [IDX_W-1:0]   stat_sel;
    logic [15:0]        stat_hits;
    logic [15:0]        stat_miss;
`endif

    int checks = 0;
    int errors = 0;

    wildcard_match_table #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_pattern (cfg_pattern),
        .cfg_care    (cfg_care),
        .cfg_en      (cfg_en),
        .in_valid    (in_valid),
        .in_data     (in_data),
`ifdef WILDCARD_MATCH_STATS_EN
        .stat_sel    (stat_sel),
        .stat_hits   (stat_hits),
        .stat_miss   (stat_miss),
`endif
        .out_valid   (out_valid),
        .out_hit     (out_hit),
        .out_idx     (out_idx),
        .out_hitmap  (out_hitmap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_pat  [ENTRIES];
    logic [WIDTH-1:0] m_care [ENTRIES];
    logic             m_en   [ENTRIES];
    logic [RW-1:0]    exp_q[$];
`ifdef WILDCARD_MATCH_STATS_EN
    int               m_hits [ENTRIES];
    int               m_miss;
`endif

    function automatic void model_clear();
        for (int e = 0; e < ENTRIES; e++) begin
            m_pat[e] = '0; m_care[e] = '0; m_en[e] = 1'b0;
`ifdef WILDCARD_MATCH_STATS_EN
            m_hits[e] = 0;
`endif
        end
`ifdef WILDCARD_MATCH_STATS_EN
        m_miss = 0;
`endif
        exp_q.delete();
        exp_q.push_back('0);   // output register contents right after reset
    endfunction

    // Scan from the top entry down so the last match recorded is the lowest.
    function automatic logic [RW-1:0] model_lookup(input logic [WIDTH-1:0] d);
        logic [ENTRIES-1:0] map = '0;
        logic               hit = 1'b0;
        logic [IDX_W-1:0]   idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (m_en[e] && ((d & m_care[e]) == (m_pat[e] & m_care[e]))) begin
                map[e] = 1'b1;
                hit    = 1'b1;
                idx    = IDX_W'(e);
            end
        end
        return {1'b1, hit, idx, map};
    endfunction

    // One clock cycle: drive inputs at negedge, sample #1 after posedge.
    // got/want are the output observed after this edge and its model value.
    task automatic drive(input logic we, input logic [IDX_W-1:0] widx,
                         input logic [WIDTH-1:0] wpat, input logic [WIDTH-1:0] wcare,
                         input logic wen, input logic v, input logic [WIDTH-1:0] d,
                         output logic [RW-1:0] got, output logic [RW-1:0] want);
        @(negedge clk);
        cfg_we = we; cfg_idx = widx; cfg_pattern = wpat; cfg_care = wcare; cfg_en = wen;
        in_valid = v; in_data = d;
        exp_q.push_back(v ? model_lookup(d) : '0);
        @(posedge clk);
        want = exp_q.pop_front();
`ifdef WILDCARD_MATCH_STATS_EN
        if (want[RW-1] && want[RW-2]) begin
            if (m_hits[int'(want[ENTRIES +: IDX_W])] < 65535)
                m_hits[int'(want[ENTRIES +: IDX_W])]++;
        end else if (want[RW-1]) begin
            if (m_miss < 65535) m_miss++;
        end
`endif
        if (we && int'(widx) < ENTRIES) begin
            m_pat[widx] = wpat; m_care[widx] = wcare; m_en[widx] = wen;
`ifdef WILDCARD_MATCH_STATS_EN
            m_hits[widx] = 0;
`endif
        end
        #1;
        got = {out_valid, out_hit, out_idx, out_hitmap};
    endtask

    task automatic idle(output logic [RW-1:0] got, output logic [RW-1:0] want);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, got, want);
    endtask

    task automatic lookup(input logic [WIDTH-1:0] d, output logic [RW-1:0] got,
                          output logic [RW-1:0] want);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, d, got, want);
    endtask

    task automatic write(input logic [IDX_W-1:0] widx, input logic [WIDTH-1:0] wpat,
                         input logic [WIDTH-1:0] wcare, input logic wen,
                         output logic [RW-1:0] got, output logic [RW-1:0] want);
        drive(1'b1, widx, wpat, wcare, wen, 1'b0, '0, got, want);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_hit, out_idx, out_hitmap} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {out_valid, out_hit, out_idx, out_hitmap});
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [RW-1:0] got, want;
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_pattern = '0; cfg_care = '0;
        cfg_en = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef WILDCARD_MATCH_STATS_EN
        stat_sel = '0;
`endif
        #12;
        checks++;
        if ({out_valid, out_hit, out_idx, out_hitmap} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_valid, out_hit, out_idx, out_hitmap});
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        lookup(8'hA5, got, want);
        checks++;
        if (got !== '0) begin
            errors++; $display("FAIL reset_latency1: got %h expected 00", got);
        end
        idle(got, want);
        checks++;
        if (got !== 8'b1000_0000) begin
            errors++; $display("FAIL reset_empty_lookup: got %h expected 80", got);
        end
    endtask

    task automatic test_wildcard();
        logic [RW-1:0] got, want;
        write(2'd1, 8'b1010_0000, 8'b1111_0000, 1'b1, got, want);
        lookup(8'hA3, got, want);
        lookup(8'hB3, got, want);
        checks++;
        if (got !== 8'b1101_0010) begin
            errors++; $display("FAIL wildcard_hit_A3: got %h expected d2", got);
        end
        idle(got, want);
        checks++;
        if (got !== 8'b1000_0000) begin
            errors++; $display("FAIL wildcard_miss_B3: got %h expected 80", got);
        end
        idle(got, want);
        checks++;
        if (got !== '0) begin
            errors++; $display("FAIL wildcard_idle: got %h expected 00", got);
        end
    endtask

    task automatic test_priority();
        logic [RW-1:0] got, want;
        write(2'd0, 8'h00, 8'h00, 1'b1, got, want);
        write(2'd2, 8'h5A, 8'hFF, 1'b1, got, want);
        lookup(8'h5A, got, want);
        write(2'd0, 8'h00, 8'h00, 1'b0, got, want);
        checks++;
        if (got !== 8'b1100_0101) begin
            errors++; $display("FAIL priority_lowest: got %h expected c5", got);
        end
        lookup(8'h5A, got, want);
        idle(got, want);
        checks++;
        if (got !== 8'b1110_0100) begin
            errors++; $display("FAIL priority_disabled0: got %h expected e4", got);
        end
    endtask

    task automatic test_collision();
        logic [RW-1:0] got, want;
        drive(1'b1, 2'd3, 8'h77, 8'hFF, 1'b1, 1'b1, 8'h77, got, want);
        lookup(8'h77, got, want);
        checks++;
        if (got !== 8'b1000_0000) begin
            errors++; $display("FAIL collision_old_table: got %h expected 80", got);
        end
        idle(got, want);
        checks++;
        if (got !== 8'b1111_1000) begin
            errors++; $display("FAIL collision_new_entry: got %h expected f8", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] got, want;
        logic [WIDTH-1:0] data [5];
        data[0] = 8'h77; data[1] = 8'h5A; data[2] = 8'hA3; data[3] = 8'h00; data[4] = 8'hB3;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) lookup(data[i], got, want);
            else       idle(got, want);
            if (i > 0) begin
                checks++;
                if (got !== want || got[RW-1] !== 1'b1) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: got %h expected %h", i - 1, got, want);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [RW-1:0] got, want;
        lookup(8'hA3, got, want);
        // Second lookup on the inputs while the first sits in stage 1.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hA3; cfg_we = 1'b0; rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_no_valid[%0d]: got %b expected 0", c, out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        model_clear();
        for (int c = 0; c < 2; c++) begin
            idle(got, want);
            checks++;
            if (got !== '0) begin
                errors++; $display("FAIL midreset_flush[%0d]: got %h expected 00", c, got);
            end
        end
        lookup(8'hA3, got, want);
        idle(got, want);
        checks++;
        if (got !== 8'b1000_0000) begin
            errors++; $display("FAIL midreset_table_cleared: got %h expected 80", got);
        end
    endtask

    task automatic test_random();
        logic [RW-1:0] got, want;
        logic [WIDTH-1:0] care, d;
        int pick;
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 3);
            care = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF : (pick == 2) ? 8'hF0 : WIDTH'($urandom);
            pick = $urandom_range(0, ENTRIES - 1);
            d = ($urandom_range(0, 1) == 1)
                ? ((m_pat[pick] & m_care[pick]) | (WIDTH'($urandom) & ~m_care[pick]))
                : WIDTH'($urandom);
            drive($urandom_range(0, 3) == 0, IDX_W'($urandom), WIDTH'($urandom), care,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, d, got, want);
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", i, got, want);
            end
        end
        idle(got, want);
        checks++;
        if (got !== want) begin
            errors++; $display("FAIL random_drain: got %h expected %h", got, want);
        end
`ifdef WILDCARD_MATCH_STATS_EN
        for (int s = 0; s < ENTRIES; s++) begin
            stat_sel = IDX_W'(s);
            #1;
            checks++;
            if (int'(stat_hits) != m_hits[s]) begin
                errors++; $display("FAIL random_stat_hits[%0d]: got %0d expected %0d", s, stat_hits, m_hits[s]);
            end
        end
        checks++;
        if (int'(stat_miss) != m_miss) begin
            errors++; $display("FAIL random_stat_miss: got %0d expected %0d", stat_miss, m_miss);
        end
`endif
    endtask

`ifdef WILDCARD_MATCH_STATS_EN
    task automatic test_stats();
        logic [RW-1:0] got, want;
        do_reset();
        stat_sel = 2'd2;
        write(2'd2, 8'h5A, 8'hFF, 1'b1, got, want);
        for (int i = 0; i < 3; i++) lookup(8'h5A, got, want);
        for (int i = 0; i < 2; i++) lookup(8'h00, got, want);
        idle(got, want);
        idle(got, want);
        checks++;
        if (stat_hits !== 16'd3) begin
            errors++; $display("FAIL stats_hits: got %0d expected 3", stat_hits);
        end
        checks++;
        if (stat_miss !== 16'd2) begin
            errors++; $display("FAIL stats_miss: got %0d expected 2", stat_miss);
        end
        write(2'd2, 8'h5A, 8'hFF, 1'b1, got, want);
        checks++;
        if (stat_hits !== 16'd0) begin
            errors++; $display("FAIL stats_clear_on_write: got %0d expected 0", stat_hits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wildcard();
        test_priority();
        test_collision();
        test_back_to_back();
        test_reset_midstream();
        do_reset();
        test_random();
`ifdef WILDCARD_MATCH_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wildcard_match_table.md
Name: wildcard_match_table

Overview:
- Programmable, pipelined wildcard pattern matcher: synthesizable generalisation of casex-style decoding.
- Holds ENTRIES patterns of WIDTH bits. Each pattern has a per-bit care mask; care=0 means don't-care, the equivalent of a casex x/z bit.
- Each input word is compared against all enabled entries. Output is a hit flag, the lowest-index matching entry, and the full hit map.
- Sits in front of decode/dispatch logic that needs runtime-reconfigurable casex behaviour.

Parameters:
- WIDTH, 8, bits per data word and pattern.
- ENTRIES, 4, number of pattern entries (2..16).
- IDX_W, 2, index width; must satisfy 2**IDX_W >= ENTRIES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cfg_we  input  1  write strobe for table entry cfg_idx
- cfg_idx  input  IDX_W  entry to write
- cfg_pattern  input  WIDTH  pattern value
- cfg_care  input  WIDTH  care mask (1 = bit must match)
- cfg_en  input  1  entry enable written with the entry
- in_valid  input  1  lookup request valid
- in_data  input  WIDTH  lookup word
- out_valid  output  1  result valid
- out_hit  output  1  at least one entry matched
- out_idx  output  IDX_W  lowest matching index; 0 when no hit
- out_hitmap  output  ENTRIES  per-entry match vector

Behaviour:
- Reset (async, immediate):
  - all pattern, care and enable registers = 0;
  - all pipeline registers = 0;
  - out_valid = 0, out_hit = 0, out_idx = 0, out_hitmap = 0.
- Table write:
  - on a clk edge with cfg_we=1 and cfg_idx < ENTRIES, entry cfg_idx takes {cfg_pattern, cfg_care, cfg_en};
  - cfg_idx >= ENTRIES: write is ignored, no state change.
- Match rule for entry i: en[i] && (((in_data ^ pattern[i]) & care[i]) == 0).
  - Enabled entry with care = 0: matches every word.
  - Disabled entry: never matches.
- Pipeline, fixed latency 2 cycles, no backpressure, one lookup accepted per cycle:
  - Stage 1 (edge N): registers the stage-1 valid flag and the hitmap computed from in_data and the current table.
  - Stage 2 (edge N+1): out_valid, out_hitmap and out_hit = |hitmap are registered; out_idx = lowest set bit of hitmap.
- Invalid input (in_valid=0):
  - flows through as out_valid=0 two cycles later;
  - out_hit, out_idx and out_hitmap are forced to 0 whenever out_valid=0.
- Write and lookup in the same cycle:
  - the lookup uses the table contents from before the edge;
  - the new entry affects lookups presented from the next cycle on.
- Back-to-back lookups produce back-to-back results in order; no bubbles are inserted.
- Reset asserted mid-stream: in-flight lookups are discarded and the table is cleared. The first output after reset deasserts reflects only inputs presented after deassertion.
- Multiple matches: out_idx is the lowest index; out_hitmap shows every matching entry.

Optional Feature:
- Macro: WILDCARD_MATCH_STATS_EN.
- When defined:
  - adds input stat_sel[IDX_W] and outputs stat_hits[15:0] and stat_miss[15:0];
  - each entry has a 16-bit saturating counter, incremented when that entry is the winning out_idx of a valid hit;
  - stat_miss counts valid lookups with no hit, saturating at 16'hFFFF;
  - stat_hits is a combinational read of the counter selected by stat_sel (0 if stat_sel >= ENTRIES);
  - rst clears all counters; writing an entry clears that entry's counter on the same edge.
- When not defined: none of these ports or counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst, then check every output is 0. With an empty table, lookup 8'hA5 -> two cycles later out_valid=1, out_hit=0, out_idx=0, out_hitmap=4'b0000.
- Wildcard match:
  - Program entry 1 with pattern=8'b1010_0000, care=8'b1111_0000, en=1.
  - Lookups 8'hA3 then 8'hB3 -> hit, out_idx=1, hitmap=4'b0010; then out_hit=0.
- Priority:
  - Program entry 0 = {8'h00, care 8'h00, en 1} and entry 2 = {8'h5A, 8'hFF, 1}.
  - Lookup 8'h5A -> out_idx=0, hitmap=4'b0101.
  - Disable entry 0 -> the same lookup gives out_idx=2.
- Write/lookup collision: in the same cycle, write entry 3 = {8'h77, 8'hFF, 1} and look up 8'h77 -> miss. The next-cycle lookup of 8'h77 -> hit, idx=3.
- Streaming and reset:
  - Send 5 consecutive valid lookups -> 5 consecutive valid results, in order, each 2 cycles later.
  - Assert rst while 2 lookups are in flight -> no out_valid pulses appear for them, and the table is cleared.
- Stats (WILDCARD_MATCH_STATS_EN): 3 hits on entry 2 and 2 misses -> stat_sel=2 gives stat_hits=3, and stat_miss=2. Then rewrite entry 2 -> stat_hits=0.
